// File: rtl/sram_resp.sv
// ---------------------------------------------------------------------------
// sram_resp -- single-outstanding request/response SRAM model.
//
// Accepts one request at a time over a valid/ready handshake, waits LATENCY
// cycles, performs a 32-bit word access on a 2^DEPTH_LOG2-word array and
// presents the result until the initiator takes it.
//
// Parameters
//   LATENCY     cycles from request accept to resp_valid (1..15)
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   BASE        byte address of word 0
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_wen             1 = write, 0 = read
//   req_addr            byte address (bits [1:0] ignored)
//   req_wdata           lane-aligned write data
//   req_wmask           byte-lane enables, [3:0] used, [7:4] ignored
//   resp_valid/resp_ready response handshake
//   resp_rdata          read word; 0 for writes and errors
//   resp_err            address outside [BASE, BASE + 4*2^DEPTH_LOG2)
//
// Optional feature (macro SRAM_RAND_DELAY_EN): an 8-bit LFSR
// (x^8+x^6+x^5+x^4+1, seed 8'hA5) adds 0-3 extra cycles of latency,
// chosen by lfsr[1:0] at the accept edge.
// ---------------------------------------------------------------------------
module sram_resp #(
  parameter int          LATENCY    = 1,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  // Wide enough for LATENCY-1 plus the optional 0-3 extra cycles.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_load;
  logic                    lat_wen;
  logic [31:0]             lat_addr;
  logic [31:0]             lat_wdata;
  logic [3:0]              lat_wmask;
  logic [31:0]             offset;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    accept;
  logic                    access;
  logic [31:0]             mem [WORDS];
  logic                    unused_bits;

  assign unused_bits = ^{req_wmask[7:4], offset[1:0]};

  // Subtracting BASE wraps addresses below BASE to huge offsets, so a single
  // upper-bits-zero test covers both ends of the window.
  assign offset   = lat_addr - BASE;
  assign in_range = (offset >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx      = offset[DEPTH_LOG2+1:2];

  assign accept = req_valid && req_ready;
  assign access = (state == S_WAIT) && (cnt == '0);

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      lat_wen    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= cnt_load;
        lat_wen   <= req_wen;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wmask <= req_wmask[3:0];
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        resp_err   <= !in_range;
        resp_rdata <= (!lat_wen && in_range) ? mem[idx] : '0;
      end
    end
  end

  // NOTE: the array has no reset; its contents are undefined until written.
  // A reset aborts WAIT asynchronously, so a pending write never commits.
  always_ff @(posedge clk) begin
    if (access && lat_wen && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_wmask[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_resp.sv
// ---------------------------------------------------------------------------
// tb_sram_resp -- self-checking bench for sram_resp (LATENCY=4).
// Expected responses come from a word-level memory model and are queued at
// request time, then popped and compared when resp_valid appears.
// ---------------------------------------------------------------------------
module tb_sram_resp;

  localparam int          LAT   = 4;
  localparam int          DLOG  = 10;
  localparam int          WORDS = 1 << DLOG;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] mdata [int];
  logic [7:0]  ref_lfsr;

  sram_resp #(.LATENCY(LAT), .DEPTH_LOG2(DLOG), .BASE(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'hA5, steps every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 8'hA5;
    else        ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Applies one access to the model and returns the expected response.
  // Called at the negedge before the accept edge, so ref_lfsr holds the
  // value the DUT samples at accept.
  function automatic exp_t model_access(input logic wen, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [7:0] wmask);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] w;
    int          idx;
    off     = addr - BASE;
    e.err   = (off >= 32'(4 * WORDS));
    e.rdata = '0;
    idx     = int'(off >> 2);
    if (!e.err) begin
      w = mdata.exists(idx) ? mdata[idx] : 32'h0;
      if (wen) begin
        for (int i = 0; i < 4; i++) if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mdata[idx] = w;
      end else begin
        e.rdata = w;
      end
    end
`ifdef SRAM_RAND_DELAY_EN
    e.lat = LAT + int'(ref_lfsr[1:0]);
`else
    e.lat = LAT;
`endif
    return e;
  endfunction

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] wmask, input int hold, input bit early);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    sb.push_back(model_access(wen, addr, wdata, wmask));
    resp_ready = early;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wmask  = wmask;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = 8'($urandom);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid) seen = 1'b1;
      else check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    end
    e = sb.pop_front();
    if (!seen) begin
      check("resp_timeout", 32'd0, 32'd1);
      resp_ready = 1'b0;
      return;
    end
    check("latency", lat, e.lat);
`ifdef SRAM_RAND_DELAY_EN
    check("lat_range", {31'd0, (lat >= LAT && lat <= LAT + 3)}, 32'd1);
`endif
    check("rdata", resp_rdata, e.rdata);
    check("err", {31'd0, resp_err}, {31'd0, e.err});
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", {31'd0, resp_valid}, 32'd1);
        check("hold_rdata", resp_rdata, e.rdata);
        check("hold_ready", {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    check("post_hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Basic write/read and partial-lane update; mask bits [7:4] ignored.
    issue(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 8'h0F, 0, 1'b0);
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 1'b0);
    issue(1'b0, 32'h8000_0010, 32'h0,         8'h00, 0, 1'b0);
    issue(1'b1, 32'h8000_0010, 32'h0000_AA00, 8'hF2, 1, 1'b0);
    issue(1'b0, 32'h8000_0013, 32'h0,         8'h00, 0, 1'b0);
    // Zero mask still responds and changes nothing.
    issue(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'h00, 0, 1'b0);
    issue(1'b0, 32'h8000_0010, 32'h0,         8'h00, 0, 1'b0);

    // Window edges and out-of-range accesses.
    issue(1'b1, 32'h8000_0FFC, 32'h1357_9BDF, 8'h0F, 0, 1'b0);
    issue(1'b0, 32'h8000_0FFC, 32'h0,         8'h00, 0, 1'b0);
    issue(1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00, 0, 1'b0);
    issue(1'b0, BASE + 32'(4 * WORDS), 32'h0, 8'h00, 0, 1'b0);
    issue(1'b1, BASE + 32'(4 * WORDS), 32'hBAD0_BAD0, 8'h0F, 0, 1'b0);
    issue(1'b1, 32'h7FFF_FFFC, 32'hBAD1_BAD1, 8'h0F, 0, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h0,         8'h00, 0, 1'b0);

    // Response held for 5 cycles, then early resp_ready.
    issue(1'b0, 32'h8000_0010, 32'h0, 8'h00, 5, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h0, 8'h00, 0, 1'b1);

    // Reset while a write is pending in WAIT: the write must be dropped.
    issue(1'b1, 32'h8000_0020, 32'h1111_1111, 8'h0F, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    req_wmask = 8'h0F;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h8000_0020, 32'h0, 8'h00, 0, 1'b0);

    // Random traffic over eight pre-initialised words.
    for (int k = 0; k < 8; k++)
      issue(1'b1, 32'h8000_0100 + 32'(4 * k), $urandom, 8'h0F, 0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      logic [31:0] a;
      a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        issue(1'b1, a, $urandom, 8'($urandom), $urandom_range(0, 2), 1'b0);
      else
        issue(1'b0, a, 32'h0, 8'h00, $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from request accept to response valid (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words.
REQ-003 SHALL have parameter BASE, default 32'h80000000, meaning byte address of word 0.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_wen  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  write data, already lane-aligned by the initiator.
REQ-011 req_wmask  input  8  byte-lane enables; bits [3:0] used, [7:4] ignored.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  full read word; 0 for writes and errors.
REQ-015 resp_err  output  1  address outside [BASE, BASE + 4*2^DEPTH_LOG2).

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-018 When req_valid && req_ready is high at an edge, the block SHALL latch wen, addr, wdata and wmask, load the delay counter with LATENCY-1, and enter WAIT.
REQ-019 In WAIT, the counter SHALL decrement each cycle; the access SHALL be performed in the cycle the counter is 0, followed by a transition to RESP.
REQ-020 resp_valid SHALL rise exactly LATENCY cycles after the accept edge, absent the configured extra delay.
REQ-021 Word index SHALL be (addr - BASE) >> 2, truncated to DEPTH_LOG2 bits; addr[1:0] SHALL be ignored.
REQ-022 Writes SHALL update only the bytes whose wmask[i] is 1; a write with mask 0 SHALL still produce a response.
REQ-023 Reads SHALL return the whole word registered into resp_rdata; sub-word extraction is the initiator's job.
REQ-024 Out-of-range accesses SHALL set resp_err=1 and resp_rdata=0, and SHALL NOT modify memory.
REQ-025 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready, then the FSM SHALL return to IDLE.
REQ-026 resp_ready held high early SHALL have no effect outside RESP.
REQ-027 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest next accept is the cycle after the return to IDLE.
REQ-028 Back-to-back reads SHALL see data from any write whose response has already completed.

Reset
REQ-029 While rst_n=0, outputs SHALL be: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-030 Memory contents SHALL NOT be reset and are undefined until written.
REQ-031 A reset asserted in WAIT SHALL drop the pending access; an uncommitted write SHALL NOT reach memory.
REQ-032 A reset asserted in RESP SHALL discard the response.

Configuration
REQ-033 Macro SRAM_RAND_DELAY_EN SHALL be supported.
REQ-034 When SRAM_RAND_DELAY_EN is defined, an 8-bit LFSR SHALL be added:
- polynomial x^8+x^6+x^5+x^4+1
- reset to 8'hA5
- advances every cycle
REQ-035 When SRAM_RAND_DELAY_EN is defined, lfsr[1:0] sampled at accept SHALL be added to the counter load, giving an extra 0-3 cycles.
REQ-036 When SRAM_RAND_DELAY_EN is undefined, no LFSR SHALL exist and latency SHALL be exactly LATENCY.

Verification
REQ-037 Write 0x80000010, data 0xDEADBEEF, mask 0xF; then read 0x80000010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at accept+LATENCY.
REQ-038 Over that word, write data 0x0000AA00, mask 0x2; read -> 0xDEADAAEF.
REQ-039 Read 0x7FFFFFFC and read BASE+4*1024 -> resp_err=1, rdata=0; a prior write to 0x80000000 is unchanged.
REQ-040 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable and req_ready=0 throughout; handshake on cycle 6 -> IDLE the next cycle.
REQ-041 Pulse rst_n low one cycle after accepting a write of 0x12345678 with LATENCY=4 -> resp_valid=0, req_ready=1; a subsequent read does not return 0x12345678.
REQ-042 With SRAM_RAND_DELAY_EN defined, run 100 reads -> latency always in LATENCY..LATENCY+3, and each extra delay matches the reference LFSR model.
